// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the 7-segment scan driver.
// Segment vectors are {dp,g,f,e,d,c,b,a} in logical polarity (1 = lit)
// until they pass through pol() on their way to the pins.
package seg7_pkg;

   typedef logic [3:0] bcd_t;

   // Slot phase: anodes are held off while the phase is PH_BLANK.
   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_DRIVE = 1'b1
   } phase_t;

   localparam logic [7:0] SEG_OFF = 8'h00;

   // Map a logical segment vector onto the board's pin polarity.
   function automatic logic [7:0] pol(input logic [7:0] vec, input logic active_low);
      return active_low ? ~vec : vec;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD/hex to 7-segment decoder, logical polarity.
// Codes 0xA-0xF produce hex glyphs; bit 7 carries the fixed DP parameter.
module bcd_to_7seg
   import seg7_pkg::*;
#(
   parameter logic DP = 1'b0
) (
   input  bcd_t       bcd,
   output logic [7:0] seg
);

   logic [6:0] glyph;

   // Glyph lookup, segment order {g,f,e,d,c,b,a}.
   always_comb begin
      // NOTE: every output of an always_comb gets a value before the case so no path leaves it unassigned and a latch is never inferred.
      glyph = 7'h00;
      case (bcd)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         4'hF: glyph = 7'h71;
         default: glyph = 7'h00;
      endcase
   end

   assign seg = {DP, glyph};

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit 7-segment driver.
// Digits are snapshotted once per frame, scanned digit 0 first, one digit
// per SCAN_DIV-cycle slot, with BLANK_CYCLES of all-anodes-off at the start
// of every slot. Outputs are registered, one cycle behind tick/idx.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int   N_DIGITS       = 4,
   parameter int   SCAN_DIV       = 50000,
   parameter int   BLANK_CYCLES   = 500,
   parameter logic LZ_SUPPRESS    = 1'b1,
   parameter logic SEG_ACTIVE_LOW = 1'b1,
   parameter logic AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] bcd_in,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic [N_DIGITS-1:0]   blank_in,
   output logic [7:0]            seg,
   output logic [N_DIGITS-1:0]   an,
   output logic                  frame_start
);

   localparam int TW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(N_DIGITS);

   localparam logic [TW-1:0]       TICK_LAST = TW'(SCAN_DIV - 1);
   localparam logic [TW-1:0]       BLANK_END = TW'(BLANK_CYCLES);
   localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] AN_OFF    = {N_DIGITS{AN_ACTIVE_LOW}};

   logic [TW-1:0]       tick;
   logic [IW-1:0]       idx;
   logic                snap;

   bcd_t                shadow_bcd [N_DIGITS];
   logic [N_DIGITS-1:0] shadow_dp;
   logic [N_DIGITS-1:0] shadow_blank;
   logic [N_DIGITS-1:0] lz_mask;

   phase_t              phase;
   logic                lit;
   bcd_t                cur_bcd;
   logic [7:0]          dec_seg;
   logic [7:0]          seg_next;
   logic [N_DIGITS-1:0] an_next;

   // A new frame begins at the first tick of digit 0.
   assign snap = (tick == '0) && (idx == '0);

   // Slot timer and digit index; idx advances when tick wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick <= '0;
         idx  <= '0;
      end else if (tick == TICK_LAST) begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
         tick <= '0;
         idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         tick <= tick + 1'b1;
      end
   end

   // Frame snapshot: inputs are sampled only at frame start, so a display
   // frame never mixes old and new digits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: this small register array is flops, not a RAM, so clearing it in the reset branch is cheap and legal.
         for (int k = 0; k < N_DIGITS; k++) shadow_bcd[k] <= '0;
         shadow_dp    <= '0;
         shadow_blank <= '0;
      end else if (snap) begin
         for (int k = 0; k < N_DIGITS; k++) shadow_bcd[k] <= bcd_in[4*k +: 4];
         shadow_dp    <= dp_in;
         shadow_blank <= blank_in;
      end
   end

   // Leading-zero mask: digit k is dark when it and every digit above it is
   // a plain zero (no dp, not blanked). Digit 0 always stays lit.
   always_comb begin : lz_calc
      logic upper_zero;
      upper_zero = 1'b1;
      lz_mask    = '0;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         upper_zero = upper_zero && (shadow_bcd[k] == 4'd0) &&
                      !shadow_dp[k] && !shadow_blank[k];
         lz_mask[k] = LZ_SUPPRESS && upper_zero;
      end
   end

   assign cur_bcd = shadow_bcd[idx];

   bcd_to_7seg #(
      .DP (1'b0)
   ) u_dec (
      .bcd (cur_bcd),
      .seg (dec_seg)
   );

   // Next output values in logical polarity: one anode and its glyph, or all off.
   always_comb begin
      phase    = (tick < BLANK_END) ? PH_BLANK : PH_DRIVE;
      lit      = (phase == PH_DRIVE) && !shadow_blank[idx] && !lz_mask[idx];
      an_next  = '0;
      seg_next = SEG_OFF;
      if (lit) begin
         an_next[idx] = 1'b1;
         seg_next     = dec_seg | {shadow_dp[idx], 7'b000_0000};
      end
   end

   // Output registers, polarity-mapped onto the pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg         <= pol(SEG_OFF, SEG_ACTIVE_LOW);
         an          <= AN_OFF;
         frame_start <= 1'b0;
      end else begin
         seg         <= pol(seg_next, SEG_ACTIVE_LOW);
         an          <= an_next ^ AN_OFF;
         frame_start <= snap;
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with N_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2,
// active-low segments and anodes. Two instances share the inputs: one with
// leading-zero suppression off, one with it on.
module tb_seg7_scan_mux;

   typedef struct {
      string       name;
      logic [15:0] bcd;
      logic [3:0]  dp;
      logic [3:0]  blank;
      bit          lz;
      logic [3:0]  dark;     // expected dark digits
      logic [7:0]  seg [4];  // expected pin value of each lit digit
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bcd_in   = '0;
   logic [3:0]  dp_in    = '0;
   logic [3:0]  blank_in = '0;

   logic [7:0]  seg0, seg1;
   logic [3:0]  an0, an1;
   logic        fs0, fs1;

   int vectors     = 0;
   int miscompares = 0;
   bit mon_en      = 1'b0;

   always #5 clk = ~clk;

   seg7_scan_mux #(
      .N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
      .LZ_SUPPRESS(1'b0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut0 (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .blank_in(blank_in),
      .seg(seg0), .an(an0), .frame_start(fs0)
   );

   seg7_scan_mux #(
      .N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
      .LZ_SUPPRESS(1'b1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
   ) dut1 (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .blank_in(blank_in),
      .seg(seg1), .an(an1), .frame_start(fs1)
   );

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %02h, expected %02h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [15:0] bcd,
                               input logic [3:0] dp, input logic [3:0] blank,
                               input bit lz, input logic [3:0] dark,
                               input logic [7:0] s3, input logic [7:0] s2,
                               input logic [7:0] s1, input logic [7:0] s0);
      vec_t v;
      v.name = name; v.bcd = bcd; v.dp = dp; v.blank = blank; v.lz = lz; v.dark = dark;
      v.seg[0] = s0; v.seg[1] = s1; v.seg[2] = s2; v.seg[3] = s3;
      return v;
   endfunction

   // Cycle c counts clock edges since reset release, starting at 1.
   // After edge c the outputs reflect slot ((c-1)/8)%4, tick (c-1)%8.
   task automatic check_cycle(input vec_t v, input int c);
      int         t, d;
      logic [3:0] exp_an;
      logic [7:0] exp_seg;
      logic       exp_fs;
      logic [3:0] act_an;
      logic [7:0] act_seg;
      logic       act_fs;
      t = (c - 1) % 8;
      d = ((c - 1) / 8) % 4;
      if (t < 2 || v.dark[d]) begin
         exp_an  = 4'hF;
         exp_seg = 8'hFF;
      end else begin
         exp_an  = ~(4'(1) << d);
         exp_seg = v.seg[d];
      end
      exp_fs  = (((c - 1) % 32) == 0);
      act_an  = v.lz ? an1  : an0;
      act_seg = v.lz ? seg1 : seg0;
      act_fs  = v.lz ? fs1  : fs0;
      check($sformatf("%s c%0d an",  v.name, c), {4'h0, act_an}, {4'h0, exp_an});
      check($sformatf("%s c%0d seg", v.name, c), act_seg, exp_seg);
      check($sformatf("%s c%0d frame_start", v.name, c), {7'h0, act_fs}, {7'h0, exp_fs});
   endtask

   // Reset, load inputs while in reset, release between clock edges.
   task automatic start(input logic [15:0] b, input logic [3:0] dp, input logic [3:0] bl);
      rst = 1'b1;
      @(negedge clk);
      bcd_in   = b;
      dp_in    = dp;
      blank_in = bl;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // At most one anode low at any time, on both instances.
   always @(negedge clk) begin
      if (mon_en) begin
         check("onehot0 an dut0", 8'($onehot0(~an0)), 8'd1);
         check("onehot0 an dut1", 8'($onehot0(~an1)), 8'd1);
      end
   end

   initial begin
      vec_t vecs [7];
      vec_t r1234, r9999, r5678;

      r1234 = mk("scan_1234", 16'h1234, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'hF9, 8'hA4, 8'hB0, 8'h99);
      r9999 = mk("tear_9999", 16'h9999, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h90, 8'h90, 8'h90, 8'h90);
      r5678 = mk("rst_5678",  16'h5678, 4'b0000, 4'b0000, 1'b0, 4'b0000, 8'h92, 8'h82, 8'hF8, 8'h80);

      vecs[0] = r1234;
      vecs[1] = mk("lz_0042",    16'h0042, 4'b0000, 4'b0000, 1'b1, 4'b1100, 8'hFF, 8'hFF, 8'h99, 8'hA4);
      vecs[2] = mk("lz_0000",    16'h0000, 4'b0000, 4'b0000, 1'b1, 4'b1110, 8'hFF, 8'hFF, 8'hFF, 8'hC0);
      vecs[3] = mk("lz_dp_0005", 16'h0005, 4'b0100, 4'b0000, 1'b1, 4'b1000, 8'hFF, 8'h40, 8'hC0, 8'h92);
      vecs[4] = mk("blank_d1",   16'h1234, 4'b0000, 4'b0010, 1'b0, 4'b0010, 8'hF9, 8'hA4, 8'hFF, 8'h99);
      vecs[5] = mk("hex_abef",   16'hABEF, 4'b1000, 4'b0000, 1'b0, 4'b0000, 8'h08, 8'h83, 8'h86, 8'h8E);
      vecs[6] = mk("lz_blank3",  16'h0007, 4'b0000, 4'b1000, 1'b1, 4'b1000, 8'hFF, 8'hC0, 8'hC0, 8'hF8);

      // Held in reset: outputs stay inactive whatever the inputs do.
      rst = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bcd_in   = 16'h1111 * 16'(i + 3);
         dp_in    = 4'(i);
         blank_in = 4'(~i);
         @(posedge clk);
         #1;
         check($sformatf("reset c%0d an0", i),  {4'h0, an0}, 8'h0F);
         check($sformatf("reset c%0d seg0", i), seg0, 8'hFF);
         check($sformatf("reset c%0d fs0", i),  {7'h0, fs0}, 8'h00);
         check($sformatf("reset c%0d an1", i),  {4'h0, an1}, 8'h0F);
         check($sformatf("reset c%0d seg1", i), seg1, 8'hFF);
         check($sformatf("reset c%0d fs1", i),  {7'h0, fs1}, 8'h00);
      end

      // One full frame per table entry, from reset release.
      for (int v = 0; v < 7; v++) begin
         start(vecs[v].bcd, vecs[v].dp, vecs[v].blank);
         for (int c = 1; c <= 32; c++) begin
            @(posedge clk);
            #1;
            check_cycle(vecs[v], c);
         end
      end

      // Tearing: inputs change during digit 1; the frame keeps 1234 and
      // 9999 appears only from the next snapshot.
      start(16'h1234, 4'b0000, 4'b0000);
      for (int c = 1; c <= 64; c++) begin
         @(posedge clk);
         #1;
         check_cycle((c <= 32) ? r1234 : r9999, c);
         if (c == 12) bcd_in = 16'h9999;
      end

      // Reset pulse in the middle of digit 2 DRIVE.
      start(16'h1234, 4'b0000, 4'b0000);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         check_cycle(r1234, c);
      end
      #2;
      rst = 1'b1;
      #1;
      check("midreset async an0",  {4'h0, an0}, 8'h0F);
      check("midreset async seg0", seg0, 8'hFF);
      check("midreset async fs0",  {7'h0, fs0}, 8'h00);
      bcd_in = 16'h5678;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk);
         #1;
         check_cycle(r5678, c);
      end

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
